// File: rtl/syn_gpu_poly_seq.sv
// Polygon sequencer: walks an N-vertex buffer and issues each edge, closing edge
// included, as a line job to the drawer with valid/ready issue and done completion.
module syn_gpu_poly_seq #(
    parameter int MAX_VERTS = 8,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int VIDX_W    = $clog2(MAX_VERTS)
) (
    input  logic              clk_ir,
    input  logic              rst_il,
    input  logic              vtx_wr_en_i,
    input  logic [VIDX_W-1:0] vtx_wr_idx_i,
    input  logic [X_W-1:0]    vtx_x_i,
    input  logic [Y_W-1:0]    vtx_y_i,
    input  logic [VIDX_W:0]   num_verts_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              line_valid_o,
    input  logic              line_ready_i,
    output logic [X_W-1:0]    line_x0_o,
    output logic [Y_W-1:0]    line_y0_o,
    output logic [X_W-1:0]    line_x1_o,
    output logic [Y_W-1:0]    line_y1_o,
    input  logic              line_done_i,
    output logic              busy_o,
    output logic              poly_done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        IDLE_S,
        ISSUE_S,
        WAIT_S,
        DRAIN_S,
        DONE_S
    } state_t;

    localparam logic [VIDX_W:0] CNT_ONE = (VIDX_W+1)'(1);
    localparam logic [VIDX_W:0] CNT_TWO = (VIDX_W+1)'(2);
    localparam logic [VIDX_W:0] CNT_MAX = (VIDX_W+1)'(MAX_VERTS);

    logic [X_W-1:0]    vx_mem [MAX_VERTS];
    logic [Y_W-1:0]    vy_mem [MAX_VERTS];

    state_t            state_q, state_d;
    logic [VIDX_W:0]   n_q, n_d;
    logic [VIDX_W:0]   e_q, e_d;
    logic [VIDX_W:0]   e_inc;
    logic [VIDX_W:0]   last_edge;
    logic              load_ep;
    logic              err_d;
    logic [VIDX_W-1:0] idx0, idx1;

    // NOTE: the vertex buffer is plain storage without reset; firmware always
    // loads it before starting, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk_ir) begin
        if (vtx_wr_en_i && state_q == IDLE_S) begin
            vx_mem[vtx_wr_idx_i] <= vtx_x_i;
            vy_mem[vtx_wr_idx_i] <= vtx_y_i;
        end
    end

    // A two-vertex polygon is a single segment, so there is no closing edge.
    assign last_edge = (n_q == CNT_TWO) ? CNT_ONE : n_q;
    assign e_inc     = e_q + CNT_ONE;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        e_d     = e_q;
        load_ep = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE_S: begin
                if (start_i && !abort_i) begin
                    if (num_verts_i < CNT_TWO || num_verts_i > CNT_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        n_d     = num_verts_i;
                        e_d     = '0;
                        load_ep = 1'b1;
                        state_d = ISSUE_S;
                    end
                end
            end
            ISSUE_S: begin
                if (line_ready_i) begin
                    state_d = abort_i ? DRAIN_S : WAIT_S;
                end else if (abort_i) begin
                    state_d = IDLE_S;
                end
            end
            WAIT_S: begin
                if (line_done_i) begin
                    if (abort_i) begin
                        state_d = IDLE_S;
                    end else begin
                        e_d = e_inc;
                        if (e_inc == last_edge) begin
                            state_d = DONE_S;
                        end else begin
                            load_ep = 1'b1;
                            state_d = ISSUE_S;
                        end
                    end
                end else if (abort_i) begin
                    state_d = DRAIN_S;
                end
            end
            DRAIN_S: begin
                if (line_done_i) begin
                    state_d = IDLE_S;
                end
            end
            DONE_S: begin
                state_d = IDLE_S;
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase
    end

    // The far endpoint wraps to vertex 0 after index N-1, avoiding a modulo.
    always_comb begin
        idx0 = e_d[VIDX_W-1:0];
        idx1 = (e_d == n_d - CNT_ONE) ? '0 : VIDX_W'(e_d + CNT_ONE);
    end

    // NOTE: state and outputs update with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state_q      <= IDLE_S;
            n_q          <= '0;
            e_q          <= '0;
            line_valid_o <= 1'b0;
            line_x0_o    <= '0;
            line_y0_o    <= '0;
            line_x1_o    <= '0;
            line_y1_o    <= '0;
            busy_o       <= 1'b0;
            poly_done_o  <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            e_q          <= e_d;
            line_valid_o <= (state_d == ISSUE_S);
            busy_o       <= (state_d != IDLE_S);
            poly_done_o  <= (state_d == DONE_S);
            err_o        <= err_d;
            if (load_ep) begin
                line_x0_o <= vx_mem[idx0];
                line_y0_o <= vy_mem[idx0];
                line_x1_o <= vx_mem[idx1];
                line_y1_o <= vy_mem[idx1];
            end
        end
    end

endmodule
